// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Owns the valid/tag/data arrays; the tag compare itself is done by an external comparator.
module cache_ctrl #(
    parameter int TAG_W = 16,
    parameter int IDX_W = 8,
    parameter int OFF_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [31:0]      cpu_addr,
    input  logic [7:0]       cpu_wdata,
    output logic             cpu_ready,
    output logic [7:0]       cpu_rdata,
    output logic [TAG_W-1:0] cmp_tag_stored,
    output logic [TAG_W-1:0] cmp_tag_req,
    input  logic             cmp_hit,
    input  logic             cmp_chk,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [7:0]       mem_wdata,
    input  logic             mem_ack,
    input  logic             mem_rvalid,
    input  logic [7:0]       mem_rdata
);
    localparam int NUM_BLK  = 1 << IDX_W;
    localparam int NUM_BYTE = 1 << (IDX_W + OFF_W);

    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WRITE, RESP} state_t;

    state_t                      state;
    logic [31:0]                 req_addr;
    logic                        req_we;
    logic [7:0]                  req_wdata;
    logic [OFF_W-1:0]            beat_cnt;
    logic [NUM_BLK-1:0]          valid_bits;
    logic [TAG_W-1:0]            tag_mem [NUM_BLK];
    logic [7:0]                  data_mem [NUM_BYTE];

    logic [TAG_W-1:0]            req_tag;
    logic [IDX_W-1:0]            req_idx;
    logic [OFF_W-1:0]            req_off;
    logic                        hit;
    logic                        data_we;
    logic [IDX_W+OFF_W-1:0]      data_waddr;
    logic [7:0]                  data_wdata;
    logic                        tag_we;

    assign req_tag        = req_addr[31 -: TAG_W];
    assign req_idx        = req_addr[OFF_W +: IDX_W];
    assign req_off        = req_addr[OFF_W-1:0];
    assign cmp_tag_stored = tag_mem[req_idx];
    assign cmp_tag_req    = req_tag;
    // A comparator match on an invalid line is still a miss.
    assign hit            = cmp_hit & valid_bits[req_idx];

    always_comb begin
        data_we    = 1'b0;
        data_waddr = {req_idx, req_off};
        data_wdata = req_wdata;
        tag_we     = 1'b0;
        if (rst_n) begin
            if (state == LOOKUP && cmp_chk && req_we && hit) begin
                data_we = 1'b1;
            end else if (state == REFILL && mem_rvalid) begin
                data_we    = 1'b1;
                data_waddr = {req_idx, beat_cnt};
                data_wdata = mem_rdata;
                tag_we     = (beat_cnt == '1);
            end
        end
    end

    // Tag and data storage survive reset; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        if (data_we) data_mem[data_waddr] <= data_wdata;
        if (tag_we) tag_mem[req_idx] <= req_tag;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            valid_bits <= '0;
            beat_cnt   <= '0;
            cpu_ready  <= 1'b0;
            cpu_rdata  <= 8'h00;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 8'h00;
            req_addr   <= 32'h0;
            req_we     <= 1'b0;
            req_wdata  <= 8'h00;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_addr  <= cpu_addr;
                        req_we    <= cpu_we;
                        req_wdata <= cpu_wdata;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (cmp_chk) begin
                        if (req_we) begin
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= req_addr;
                            mem_wdata <= req_wdata;
                            state     <= WRITE;
                        end else if (hit) begin
                            state <= RESP;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= {req_tag, req_idx, {OFF_W{1'b0}}};
                            beat_cnt <= '0;
                            state    <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (mem_rvalid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == '1) begin
                            mem_req             <= 1'b0;
                            valid_bits[req_idx] <= 1'b1;
                            state               <= RESP;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        cpu_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                RESP: begin
                    cpu_ready <= 1'b1;
                    cpu_rdata <= data_mem[{req_idx, req_off}];
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: directed scenarios then random traffic, checked against a
// memory-image model (write-through means any cached byte equals main memory).
module tb_cache_ctrl;
    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ready;
    logic [7:0]  cpu_rdata;
    logic [15:0] cmp_tag_stored;
    logic [15:0] cmp_tag_req;
    logic        cmp_hit;
    logic        cmp_chk;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;
    logic        chk_en;

    int tests = 0;
    int failures = 0;

    logic [7:0]  mm [logic [31:0]];
    bit          m_valid [256];
    logic [15:0] m_tag [256];
    logic [7:0]  last_rdata;

    cache_ctrl #(.TAG_W(16), .IDX_W(8), .OFF_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .cmp_tag_stored(cmp_tag_stored), .cmp_tag_req(cmp_tag_req),
        .cmp_hit(cmp_hit), .cmp_chk(cmp_chk),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // The bench plays the 16b equality comparator.
    assign cmp_hit = (cmp_tag_stored == cmp_tag_req);
    assign cmp_chk = chk_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mm.exists(a)) return mm[a];
        return a[7:0] ^ 8'h5A ^ a[31:24] ^ a[23:16] ^ a[15:8] ^ 8'h03;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Holds cmp_chk low in LOOKUP while throwing junk at the idle-only inputs.
    task automatic lookup_stall(input int stall);
        for (int k = 0; k < stall; k++) begin
            chk_en = 1'b0;
            check("stall_mem_req", 32'(mem_req), 32'h0);
            check("stall_ready", 32'(cpu_ready), 32'h0);
            cpu_req    = 1'($urandom_range(0, 1));
            cpu_we     = 1'($urandom_range(0, 1));
            cpu_addr   = $urandom;
            cpu_wdata  = 8'($urandom);
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = 8'($urandom);
            step();
        end
        chk_en     = 1'b1;
        cpu_req    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input int stall, input int gap_max,
                           output logic [7:0] got, output logic saw_hit);
        logic       exp_hit;
        logic [7:0] exp_byte;
        exp_hit  = m_valid[a[15:8]] && (m_tag[a[15:8]] == a[31:16]);
        exp_byte = mem_rd(a);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a; cpu_wdata = 8'($urandom);
        step();
        cpu_req = 1'b0;
        lookup_stall(stall);
        step();
        saw_hit = !mem_req;
        check("lookup_hit", 32'(saw_hit), 32'(exp_hit));
        if (exp_hit) begin
            check("hit_ready_early", 32'(cpu_ready), 32'h0);
            step();
        end else begin
            check("refill_we", 32'(mem_we), 32'h0);
            check("refill_addr", mem_addr, {a[31:8], 8'h00});
            for (int b = 0; b < 256; b++) begin
                if (gap_max > 0) begin
                    repeat ($urandom_range(0, gap_max)) begin
                        mem_rvalid = 1'b0;
                        step();
                    end
                end
                if (b == 255) check("refill_req_held", 32'(mem_req), 32'h1);
                mem_rvalid = 1'b1;
                mem_rdata  = mem_rd({a[31:8], 8'(b)});
                step();
            end
            mem_rvalid = 1'b0;
            check("refill_done_req", 32'(mem_req), 32'h0);
            check("refill_ready_early", 32'(cpu_ready), 32'h0);
            step();
            m_valid[a[15:8]] = 1'b1;
            m_tag[a[15:8]]   = a[31:16];
        end
        check("read_ready", 32'(cpu_ready), 32'h1);
        check("read_rdata", 32'(cpu_rdata), 32'(exp_byte));
        got        = cpu_rdata;
        last_rdata = exp_byte;
        step();
        check("read_ready_pulse", 32'(cpu_ready), 32'h0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] d, input int stall,
                            input int ack_delay);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        step();
        cpu_req = 1'b0;
        lookup_stall(stall);
        step();
        check("wr_req", 32'(mem_req), 32'h1);
        check("wr_we", 32'(mem_we), 32'h1);
        check("wr_addr", mem_addr, a);
        check("wr_wdata", 32'(mem_wdata), 32'(d));
        for (int k = 0; k < ack_delay; k++) begin
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = 8'($urandom);
            step();
            check("wr_req_hold", 32'(mem_req), 32'h1);
            check("wr_ready_early", 32'(cpu_ready), 32'h0);
        end
        mem_rvalid = 1'b0;
        mem_ack    = 1'b1;
        step();
        mem_ack = 1'b0;
        check("wr_ready", 32'(cpu_ready), 32'h1);
        check("wr_req_drop", 32'(mem_req), 32'h0);
        check("wr_we_drop", 32'(mem_we), 32'h0);
        check("wr_rdata_hold", 32'(cpu_rdata), 32'(last_rdata));
        step();
        check("wr_ready_pulse", 32'(cpu_ready), 32'h0);
        mm[a] = d;
    endtask

    // Starts a refill of a known-uncached address, then resets at the given beat.
    task automatic do_abort(input logic [31:0] a, input int at_beat);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        step();
        cpu_req = 1'b0;
        step();
        check("abort_refill_start", 32'(mem_req), 32'h1);
        for (int b = 0; b < at_beat; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_rd({a[31:8], 8'(b)});
            step();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = mem_rd({a[31:8], 8'(at_beat)});
        rst_n      = 1'b0;
        step();
        check("abort_mem_req", 32'(mem_req), 32'h0);
        check("abort_mem_we", 32'(mem_we), 32'h0);
        check("abort_mem_addr", mem_addr, 32'h0);
        check("abort_ready", 32'(cpu_ready), 32'h0);
        check("abort_rdata", 32'(cpu_rdata), 32'h0);
        step();
        rst_n = 1'b1;
        repeat (20) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 8'($urandom);
            step();
        end
        mem_rvalid = 1'b0;
        check("abort_idle_req", 32'(mem_req), 32'h0);
        check("abort_idle_ready", 32'(cpu_ready), 32'h0);
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        last_rdata = 8'h00;
    endtask

    initial begin
        logic [7:0]  got;
        logic        saw_hit;
        logic [31:0] a;
        logic [7:0]  ix;

        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 8'h00;
        chk_en = 1'b1; mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 8'h00;
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        last_rdata = 8'h00;
        repeat (3) step();
        check("rst_ready", 32'(cpu_ready), 32'h0);
        check("rst_rdata", 32'(cpu_rdata), 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        rst_n = 1'b1;
        step();

        do_read(32'h0001_0203, 0, 0, got, saw_hit);
        check("first_miss", 32'(saw_hit), 32'h0);
        check("first_rdata", 32'(got), 32'h59);
        do_read(32'h0001_0203, 0, 0, got, saw_hit);
        check("repeat_hit", 32'(saw_hit), 32'h1);
        check("repeat_rdata", 32'(got), 32'h59);
        do_read(32'h0002_0203, 0, 1, got, saw_hit);
        check("new_tag_miss", 32'(saw_hit), 32'h0);
        do_read(32'h0001_0203, 0, 0, got, saw_hit);
        check("evicted_miss", 32'(saw_hit), 32'h0);
        do_read(32'h0002_0210, 0, 0, got, saw_hit);

        do_write(32'h0002_0210, 8'hAB, 0, 3);
        do_read(32'h0002_0210, 0, 0, got, saw_hit);
        check("after_write_hit", 32'(saw_hit), 32'h1);
        check("after_write_rdata", 32'(got), 32'hAB);
        do_write(32'h0003_0510, 8'h77, 1, 0);
        do_read(32'h0003_0510, 0, 0, got, saw_hit);
        check("no_allocate_miss", 32'(saw_hit), 32'h0);
        check("no_allocate_rdata", 32'(got), 32'h77);

        do_abort(32'h0004_07C8, 100);
        do_read(32'h0004_07C8, 0, 0, got, saw_hit);
        check("after_abort_miss", 32'(saw_hit), 32'h0);
        do_read(32'h0004_0701, 4, 0, got, saw_hit);
        check("stall_hit", 32'(saw_hit), 32'h1);
        do_read(32'h0003_0510, 0, 0, got, saw_hit);
        check("reset_clears_valid", 32'(saw_hit), 32'h0);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 2))
                0:       ix = 8'h02;
                1:       ix = 8'h05;
                default: ix = 8'hFF;
            endcase
            a = {16'($urandom_range(1, 3)), ix, 8'($urandom)};
            if ($urandom_range(0, 2) == 0)
                do_write(a, 8'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 2), 1, got, saw_hit);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
